serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial unsigned subtractor; the inverse operation of the team's full-adder datapath.
//  - Computes a - b - bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
//  - Intended for area-constrained datapaths that can tolerate WIDTH-cycle latency.
//  - Operands are captured on a start handshake; the result is held until the next operation.
// PARAMETERS
//  WIDTH  8  operand/result width in bits, >= 1
// PORTS
//  clk    in   1      system clock, all state on rising edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only when busy=0
//  a      in   WIDTH  minuend, captured on accepted start
//  b      in   WIDTH  subtrahend, captured on accepted start
//  bin    in   1      borrow-in, captured on accepted start
//  busy   out  1      high while in RUN
//  done   out  1      one-cycle pulse: diff/bout valid
//  diff   out  WIDTH  result (a - b - bin) mod 2^WIDTH
//  bout   out  1      final borrow: 1 iff a < b + bin (unsigned)
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, diff=0, bout=0; internal shift regs, borrow and count cleared.
//    rst overrides everything, including mid-RUN; a partial result is discarded.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE or DONE with start=1 at an edge:
//    - load A<=a, B<=b, brw<=bin, cnt<=0;
//    - go to RUN.
//  - IDLE with start=0: stay in IDLE.
//  - DONE with start=0: go to IDLE.
//  - RUN, each edge:
//    - d = A[0]^B[0]^brw;
//    - brw <= (~A[0]&B[0]) | (~(A[0]^B[0])&brw);
//    - A,B shift right 1;
//    - d shifts into the MSB of the internal result reg;
//    - cnt++.
//  - RUN with cnt==WIDTH-1 at an edge:
//    - diff <= {d, res[WIDTH-1:1]};
//    - bout <= next brw;
//    - go to DONE.
//  - Latency: start accepted at edge k -> done=1 during the cycle after edge k+WIDTH; back-to-back throughput is one op per WIDTH+1 cycles.
//  - Output flags: busy=1 only in RUN; done=1 only in DONE (exactly one cycle).
//  - diff/bout change only on entry to DONE; they hold through IDLE and the next RUN.
//  - start while busy=1 is ignored, with no queueing.
//  - a/b/bin are don't-care except at the accepting edge; changes during RUN have no effect.
//  - WIDTH=1: RUN lasts one edge.
//  - No overflow or saturation: diff wraps modulo 2^WIDTH and the wrap is flagged by bout.
// TESTING
//  1. rst 2 cycles -> busy=0, done=0, diff=0, bout=0; start=1 on the last rst cycle is ignored.
//  2. a=100, b=37, bin=0, start pulse -> done after 8 RUN edges, diff=63, bout=0, busy high exactly 8 cycles.
//  3. Borrow and wrap cases:
//     - a=5, b=9, bin=0 -> diff=252, bout=1;
//     - a=0, b=0, bin=1 -> diff=255, bout=1;
//     - a=255, b=0, bin=0 -> diff=255, bout=0.
//  4. Operand capture and start-while-busy:
//     - start a=200, b=50;
//     - at RUN cycle 3, change a=1, b=1 and pulse start;
//     - expect one done, diff=150, no second op.
//  5. Back-to-back start in the DONE cycle:
//     - a=10, b=3 followed by a=3, b=10 -> done pulses 9 cycles apart;
//     - first diff=7, bout=0; second diff=249, bout=1;
//     - first result held until the second done.
//  6. rst at RUN cycle 4 of a=100, b=37 -> next cycle IDLE with all outputs 0, no done;
//     a fresh start afterwards gives diff=63.

Source files
------------

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial unsigned subtractor, a - b - bin, one bit per clock.
// Revision : 1.0
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_brw;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_d;
    logic               w_brw_next;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    // Single full-subtractor cell working on the current LSBs
    assign w_d        = r_a[0] ^ r_b[0] ^ r_brw;
    assign w_brw_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_brw);
    assign w_last     = (r_cnt == c_CNT_LAST);

    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_next = w_d;
        end else begin : g_res_wn
            assign w_res_next = {w_d, r_res[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = start ? S_RUN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Result registers only update on the final RUN edge, so they hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_brw  <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_brw <= bin;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_brw <= w_brw_next;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_diff <= w_res_next;
                        r_bout <= w_brw_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;

endmodule
`default_nettype wire
